// File: rtl/fifo_read_packer.sv
// fifo_read_packer: read-side consumer of the byte FIFO. Pulls 8-bit entries,
// packs them little-endian into BYTES_PER_WORD-byte words, and presents them on
// a valid/ready port. A flush forces out a partial word with a byte-keep mask.

// One accumulator byte lane.
module fifo_read_packer_lane #(
  parameter int DATA_W = 8
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] lane_fill
);
  logic [DATA_W-1:0] lane_q, lane_d;

  // Lane value including a byte landing this cycle; cleared once it moves to the output slot
  always_comb begin
    lane_fill = wr_en ? wr_data : lane_q;
    lane_d    = clr ? '0 : lane_fill;
  end

  // Lane storage
  always_ff @(posedge read_clk) begin
    if (reset) lane_q <= '0;
    else       lane_q <= lane_d;
  end
endmodule

module fifo_read_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DATA_W         = 8
) (
  input  logic                             read_clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_W-1:0]                fifo_read_data,
  output logic                             fifo_read_enable,
  input  logic                             flush,
  output logic [DATA_W*BYTES_PER_WORD-1:0] word_data,
  output logic [BYTES_PER_WORD-1:0]        word_keep,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic                             flush_done
);
  localparam int BPW   = BYTES_PER_WORD;
  localparam int CNT_W = $clog2(BPW) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BPW);

  logic [CNT_W-1:0]                acc_cnt_q, acc_cnt_d;
  logic                            rd_pending_q, rd_pending_d;
  logic                            flush_pending_q, flush_pending_d;
  logic [BPW-1:0][DATA_W-1:0]      word_data_q, word_data_d;
  logic [BPW-1:0]                  word_keep_q, word_keep_d;
  logic                            word_valid_q, word_valid_d;
  logic                            flush_done_q, flush_done_d;

  logic [BPW-1:0][DATA_W-1:0]      acc_fill;
  logic [BPW-1:0]                  lane_we, fill_keep;
  logic [CNT_W-1:0]                fill_cnt;
  logic                            slot_free, fill_full, flush_fire, load;

  // Accumulator lanes; the byte returned by an accepted read lands in lane acc_cnt
  for (genvar g = 0; g < BPW; g++) begin : g_lane
    fifo_read_packer_lane #(.DATA_W(DATA_W)) u_lane (
      .read_clk  (read_clk),
      .reset     (reset),
      .wr_en     (lane_we[g]),
      .clr       (load),
      .wr_data   (fifo_read_data),
      .lane_fill (acc_fill[g])
    );
  end

  // Read issue, word load, flush completion and next-state for all control flops
  always_comb begin
    slot_free  = !word_valid_q || word_ready;
    // Byte count as it will be after this edge's in-flight byte lands
    fill_cnt   = acc_cnt_q + CNT_W'(rd_pending_q);
    fill_full  = (fill_cnt == FULL);
    // Flush waits for the in-flight byte and a free slot
    flush_fire = flush_pending_q && !rd_pending_q && slot_free;
    load       = (fill_full && slot_free) || (flush_fire && (acc_cnt_q != '0));
    fifo_read_enable = !fifo_empty && !flush_pending_q && (fill_cnt < FULL);
    for (int i = 0; i < BPW; i++) begin
      lane_we[i]   = rd_pending_q && (acc_cnt_q == CNT_W'(i));
      fill_keep[i] = (CNT_W'(i) < fill_cnt);
    end
    acc_cnt_d       = load ? '0 : fill_cnt;
    rd_pending_d    = fifo_read_enable;
    // A flush seen while one is already pending is dropped
    flush_pending_d = flush_pending_q ? !flush_fire : flush;
    word_valid_d    = load || (word_valid_q && !word_ready);
    word_data_d     = load ? acc_fill  : word_data_q;
    word_keep_d     = load ? fill_keep : word_keep_q;
    flush_done_d    = flush_fire;
  end

  // Control and output registers
  always_ff @(posedge read_clk) begin
    if (reset) begin
      acc_cnt_q       <= '0;
      rd_pending_q    <= 1'b0;
      flush_pending_q <= 1'b0;
      word_data_q     <= '0;
      word_keep_q     <= '0;
      word_valid_q    <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      acc_cnt_q       <= acc_cnt_d;
      rd_pending_q    <= rd_pending_d;
      flush_pending_q <= flush_pending_d;
      word_data_q     <= word_data_d;
      word_keep_q     <= word_keep_d;
      word_valid_q    <= word_valid_d;
      flush_done_q    <= flush_done_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_keep  = word_keep_q;
  assign word_valid = word_valid_q;
  assign flush_done = flush_done_q;
endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: a queue-backed FIFO model feeds the DUT, a byte-level
// reference model predicts words and flush events, and a negedge monitor checks them.
module tb_fifo_read_packer;
  localparam int BPW = 4;

  logic             read_clk = 1'b0;
  logic             reset, fifo_empty, fifo_read_enable, flush;
  logic [7:0]       fifo_read_data;
  logic [8*BPW-1:0] word_data;
  logic [BPW-1:0]   word_keep;
  logic             word_valid, word_ready, flush_done;

  always #5 read_clk = ~read_clk;

  fifo_read_packer #(.BYTES_PER_WORD(BPW), .DATA_W(8)) dut (
    .read_clk         (read_clk),
    .reset            (reset),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_enable (fifo_read_enable),
    .flush            (flush),
    .word_data        (word_data),
    .word_keep        (word_keep),
    .word_valid       (word_valid),
    .word_ready       (word_ready),
    .flush_done       (flush_done)
  );

  typedef struct packed { logic [8*BPW-1:0] data; logic [BPW-1:0] keep; } word_t;
  typedef struct packed { logic partial; logic [BPW-1:0] keep; } fevt_t;

  logic [7:0] fq[$];     // bytes sitting in the FIFO
  logic [7:0] part[$];   // bytes read but not yet grouped into a word
  word_t      exp_w[$];  // expected output words, in order
  fevt_t      exp_f[$];  // expected flush completions
  int         n_chk = 0, n_fail = 0, n_words = 0, n_fd = 0;
  word_t      last_w;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Little-endian word from the first n buffered bytes, unused lanes zero
  function automatic word_t pack(input int n);
    word_t w;
    w.data = '0;
    w.keep = '0;
    for (int i = 0; i < n; i++) begin
      w.data[8*i +: 8] = part[i];
      w.keep[i]        = 1'b1;
    end
    return w;
  endfunction

  // FIFO model and reference model: every accepted read pops one byte,
  // which is returned one cycle later.
  initial begin
    logic       ren, fe, fl, rs, got;
    logic [7:0] b;
    fevt_t      e;
    word_t      w;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    b = '0;
    forever begin
      @(posedge read_clk);
      ren = fifo_read_enable; fe = fifo_empty; fl = flush; rs = reset; got = 1'b0;
      if (rs === 1'b1) begin
        if (ren === 1'b1 && !fe && fq.size() != 0) b = fq.pop_front();
        part.delete(); exp_w.delete(); exp_f.delete();
      end else begin
        if (ren === 1'b1) begin
          chk(!fe, "read_when_empty", fe, 0);
          chk(exp_f.size() == 0, "read_during_flush", exp_f.size(), 0);
        end
        if (ren === 1'b1 && !fe && fq.size() != 0) begin
          b = fq.pop_front();
          got = 1'b1;
          part.push_back(b);
          if (part.size() == BPW) begin
            exp_w.push_back(pack(BPW));
            part.delete();
          end
        end
        if (fl && exp_f.size() == 0) begin
          w = pack(part.size());
          e.partial = (part.size() != 0);
          e.keep    = w.keep;
          if (part.size() != 0) begin
            exp_w.push_back(w);
            part.delete();
          end
          exp_f.push_back(e);
        end
      end
      #1;
      fifo_read_data = got ? b : 8'($urandom);
      fifo_empty     = (fq.size() == 0);
    end
  end

  // Monitor: compares presented words on handshake, flush completions, and hold stability
  initial begin
    logic  pv, pr, prst;
    word_t pw, e;
    fevt_t f;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; pw = '0;
    forever begin
      @(negedge read_clk);
      if (reset === 1'b0) begin
        if (flush_done === 1'b1) begin
          n_fd++;
          chk(exp_f.size() != 0, "flush_done_expected", 1, exp_f.size());
          if (exp_f.size() != 0) begin
            f = exp_f.pop_front();
            if (f.partial) begin
              chk(word_valid === 1'b1, "flush_word_valid", word_valid, 1);
              chk(word_keep === f.keep, "flush_word_keep", word_keep, f.keep);
            end
          end
        end
        if (pv && !pr && !prst)
          chk(word_valid === 1'b1 && {word_data, word_keep} === pw, "hold_stable",
              {word_data, word_keep}, pw);
        if (word_valid === 1'b1 && word_ready === 1'b1) begin
          chk(exp_w.size() != 0, "word_expected", word_data, 0);
          if (exp_w.size() != 0) begin
            e = exp_w.pop_front();
            chk(word_data === e.data, "word_data", word_data, e.data);
            chk(word_keep === e.keep, "word_keep", word_keep, e.keep);
            n_words++;
            last_w = {word_data, word_keep};
          end
        end
      end
      pv = (word_valid === 1'b1); pr = (word_ready === 1'b1); prst = (reset !== 1'b0);
      pw = {word_data, word_keep};
    end
  end

  task automatic step();
    @(posedge read_clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    word_ready = 1'b1;
    flush = 1'b0;
    while ((fq.size() != 0 || exp_w.size() != 0 || exp_f.size() != 0 || word_valid !== 1'b0)
           && n < budget) begin
      step();
      n++;
    end
    chk(n < budget, "drain_timeout", n, budget);
  endtask

  task automatic chk_zero(input string nm);
    chk(word_data === '0,  {nm, "_data"},  word_data, 0);
    chk(word_keep === '0,  {nm, "_keep"},  word_keep, 0);
    chk(word_valid === 0,  {nm, "_valid"}, word_valid, 0);
    chk(flush_done === 0,  {nm, "_fdone"}, flush_done, 0);
  endtask

  initial begin
    int w0, f0, n;
    reset = 1'b1; flush = 1'b0; word_ready = 1'b0;
    @(posedge read_clk);
    @(negedge read_clk);
    chk_zero("reset");
    step();
    reset = 1'b0;

    // Single word
    w0 = n_words;
    word_ready = 1'b1;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    drain(100);
    chk(n_words - w0 == 1, "t1_words", n_words - w0, 1);
    chk(last_w.data === 32'h44332211 && last_w.keep === 4'hF, "t1_word", last_w, {32'h44332211, 4'hF});

    // Stream of 8 bytes
    w0 = n_words;
    for (int i = 1; i <= 8; i++) fq.push_back(8'(i));
    drain(100);
    chk(n_words - w0 == 2, "t2_words", n_words - w0, 2);
    chk(last_w.data === 32'h08070605, "t2_last", last_w.data, 32'h08070605);

    // Backpressure: 12 bytes with the slot blocked
    w0 = n_words;
    word_ready = 1'b0;
    for (int i = 0; i < 12; i++) fq.push_back(8'(8'h21 + i));
    repeat (30) step();
    chk(fq.size() == 4, "bp_fifo_left", fq.size(), 4);
    chk(word_valid === 1'b1, "bp_valid", word_valid, 1);
    chk(fifo_read_enable === 1'b0, "bp_no_read", fifo_read_enable, 0);
    drain(100);
    chk(n_words - w0 == 3, "bp_words", n_words - w0, 3);
    chk(last_w.data === 32'h2C2B2A29, "bp_last", last_w.data, 32'h2C2B2A29);

    // Partial flush, held two cycles so the second request lands while pending
    w0 = n_words; f0 = n_fd;
    fq.push_back(8'hAA); fq.push_back(8'hBB);
    repeat (8) step();
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    drain(100);
    chk(n_words - w0 == 1, "fl_words", n_words - w0, 1);
    chk(n_fd - f0 == 1, "fl_done_count", n_fd - f0, 1);
    chk(last_w.data === 32'h0000BBAA && last_w.keep === 4'h3, "fl_word", last_w, {32'h0000BBAA, 4'h3});

    // Flush with nothing accumulated
    w0 = n_words;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge read_clk);
    chk(flush_done === 1'b0, "fe_done_early", flush_done, 0);
    step();
    chk(flush_done === 1'b1, "fe_done", flush_done, 1);
    chk(word_valid === 1'b0, "fe_no_word", word_valid, 0);
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h51 + i));
    drain(100);
    chk(n_words - w0 == 1, "fe_resume", n_words - w0, 1);
    chk(last_w.data === 32'h54535251, "fe_resume_word", last_w.data, 32'h54535251);

    // Reset with 3 bytes accumulated and 1 in flight
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'hA1 + i));
    n = 0;
    while (fq.size() != 0 && n < 50) begin step(); n++; end
    chk(n < 50, "rst_wait", n, 50);
    reset = 1'b1;
    step();
    chk_zero("midrst");
    reset = 1'b0;
    w0 = n_words;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h10 + i));
    drain(100);
    chk(n_words - w0 == 1, "rst_words", n_words - w0, 1);
    chk(last_w.data === 32'h13121110, "rst_word", last_w.data, 32'h13121110);

    // Random traffic, backpressure and flushes
    w0 = n_words;
    for (int i = 0; i < 600; i++) begin
      word_ready = ($urandom_range(3) != 0);
      if (fq.size() < 12 && $urandom_range(2) != 0) fq.push_back(8'($urandom));
      flush = (exp_f.size() == 0 && $urandom_range(24) == 0);
      step();
    end
    flush = 1'b0;
    drain(400);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain(100);
    chk(n_words - w0 > 20, "rand_words", n_words - w0, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
